sfpdiv: RTL and testbench

SFPDIV -- requirements
Module: sfpdiv

---
 rtl/sfpdiv.sv | 206 ++++++++++++++++++++
 tb/tb_sfpdiv.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sfpdiv.sv
// Small floating-point divider: sequential restoring division of the significands,
// then normalisation, round-half-up and exponent range handling.
module sfpdiv #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [formatWidth-1:0] a,
  input  logic [formatWidth-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [formatWidth-1:0] c,
  output logic                   div_by_zero
);

  localparam int QW = sigWidth + 3;
  localparam int RW = sigWidth + 2;
  localparam int EW = expWidth + 2;
  localparam int CW = $clog2(QW);

  localparam logic signed [EW-1:0] BIAS  = EW'(1 << (expWidth - 1));
  localparam logic signed [EW-1:0] EZERO = EW'(0);
  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << expWidth) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic                  sa_r;
  logic                  sb_r;
  logic [expWidth-1:0]   ea_r;
  logic [expWidth-1:0]   eb_r;
  logic [sigWidth-1:0]   mb_r;
  logic [RW-1:0]         rem_r;
  logic [QW-1:0]         q_r;
  logic [CW-1:0]         cnt_r;
  logic [formatWidth-1:0] c_r;
  logic                  dbz_r;

  logic [RW-1:0]         div_s;
  logic [RW-1:0]         diff_s;
  logic [RW-1:0]         rem_nx_s;
  logic                  qbit_s;

  logic                  sign_s;
  logic signed [EW-1:0]  exp_base_s;
  logic signed [EW-1:0]  exp_norm_s;
  logic signed [EW-1:0]  exp_fin_s;
  logic [sigWidth-1:0]   mant_s;
  logic                  rnd_s;
  logic [sigWidth:0]     mant_rnd_s;
  logic [sigWidth-1:0]   mant_fin_s;
  logic [formatWidth-1:0] res_s;
  logic                  dbz_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(QW - 1)) begin
          state_nx_s = NORM;
        end else begin
          state_nx_s = CALC;
        end
      end
      NORM: state_nx_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // One restoring-division step: the remainder stays below twice the divisor
  always_comb begin
    div_s = {1'b0, 1'b1, mb_r};
    if (rem_r >= div_s) begin
      diff_s = rem_r - div_s;
      qbit_s = 1'b1;
    end else begin
      diff_s = rem_r;
      qbit_s = 1'b0;
    end
    rem_nx_s = diff_s << 1;
  end

  // Normalise, round and classify the quotient
  always_comb begin
    sign_s     = sa_r ^ sb_r;
    exp_base_s = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + BIAS;
    if (q_r[QW-1]) begin
      mant_s     = q_r[QW-2:2];
      rnd_s      = q_r[1];
      exp_norm_s = exp_base_s;
    end else begin
      mant_s     = q_r[QW-3:1];
      rnd_s      = q_r[0];
      exp_norm_s = exp_base_s - EONE;
    end
    mant_rnd_s = {1'b0, mant_s} + {{sigWidth{1'b0}}, rnd_s};
    if (mant_rnd_s[sigWidth]) begin
      mant_fin_s = {sigWidth{1'b0}};
      exp_fin_s  = exp_norm_s + EONE;
    end else begin
      mant_fin_s = mant_rnd_s[sigWidth-1:0];
      exp_fin_s  = exp_norm_s;
    end

    dbz_s = 1'b0;
    if (eb_r == {expWidth{1'b0}}) begin
      res_s = {sign_s, {expWidth{1'b1}}, {sigWidth{1'b1}}};
      dbz_s = 1'b1;
    end else if (ea_r == {expWidth{1'b0}}) begin
      res_s = {formatWidth{1'b0}};
    end else if (exp_fin_s <= EZERO) begin
      res_s = {formatWidth{1'b0}};
    end else if (exp_fin_s > EMAX) begin
      res_s = {sign_s, {expWidth{1'b1}}, {sigWidth{1'b1}}};
    end else begin
      res_s = {sign_s, exp_fin_s[expWidth-1:0], mant_fin_s};
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_r  <= 1'b0;
      sb_r  <= 1'b0;
      ea_r  <= {expWidth{1'b0}};
      eb_r  <= {expWidth{1'b0}};
      mb_r  <= {sigWidth{1'b0}};
      rem_r <= {RW{1'b0}};
      q_r   <= {QW{1'b0}};
      cnt_r <= {CW{1'b0}};
      c_r   <= {formatWidth{1'b0}};
      dbz_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sa_r  <= a[formatWidth-1];
            sb_r  <= b[formatWidth-1];
            ea_r  <= a[formatWidth-2:sigWidth];
            eb_r  <= b[formatWidth-2:sigWidth];
            mb_r  <= b[sigWidth-1:0];
            rem_r <= {1'b0, 1'b1, a[sigWidth-1:0]};
            q_r   <= {QW{1'b0}};
            cnt_r <= {CW{1'b0}};
          end
        end
        CALC: begin
          rem_r <= rem_nx_s;
          q_r   <= {q_r[QW-2:0], qbit_s};
          cnt_r <= cnt_r + CW'(1);
        end
        NORM: begin
          c_r   <= res_s;
          dbz_r <= dbz_s;
        end
        DONE: begin
          c_r   <= c_r;
        end
        default: begin
          c_r   <= c_r;
        end
      endcase
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == DONE);
  assign c           = c_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_sfpdiv.sv
// Self-checking bench for sfpdiv: directed corner cases, back-pressure, mid-operation
// reset and randomized operands against an arithmetic reference model.
module tb_sfpdiv;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] a;
  logic [8:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] c;
  logic       div_by_zero;

  int n_checks;
  int n_errors;

  sfpdiv #(.expWidth(4), .sigWidth(4), .formatWidth(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Returns {div_by_zero, c}; quotient obtained by integer division of scaled significands
  function automatic logic [9:0] ref_div(input logic [8:0] x, input logic [8:0] y);
    int ea, eb, ma, mb, e, t, sig;
    logic s;
    s  = x[8] ^ y[8];
    ea = int'(x[7:4]);
    eb = int'(y[7:4]);
    ma = 16 + int'(x[3:0]);
    mb = 16 + int'(y[3:0]);
    if (eb == 0) return {1'b1, s, 8'hFF};
    if (ea == 0) return 10'h000;
    e = ea - eb + 8;
    if (ma >= mb) begin
      t = (ma * 32) / mb;
    end else begin
      t = (ma * 64) / mb;
      e = e - 1;
    end
    sig = (t >> 1) + (t & 1);
    if (sig == 32) begin
      sig = 16;
      e = e + 1;
    end
    if (e <= 0) return 10'h000;
    if (e > 15) return {1'b0, s, 8'hFF};
    return {1'b0, s, 4'(e), 4'(sig - 16)};
  endfunction

  task automatic run_op(input logic [8:0] av, input logic [8:0] bv,
                        input logic [9:0] want, input int hold);
    int lat;
    @(negedge clk);
    check_eq("ready_idle", in_ready, 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 9'($urandom);
    b = 9'($urandom);
    check_eq("ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, 8);
    check_eq("c", c, want[8:0]);
    check_eq("dbz", div_by_zero, want[9]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = 9'($urandom);
      b = 9'($urandom);
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_c", c, want[8:0]);
      check_eq("hold_dbz", div_by_zero, want[9]);
      check_eq("hold_ready", in_ready, 0);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_valid", out_valid, 0);
    check_eq("release_ready", in_ready, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [8:0] ra;
    logic [8:0] rb;
    int pulses;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 9'h000;
    b         = 9'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_c", c, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    run_op(9'h088, 9'h080, 10'h088, 0);
    run_op(9'h080, 9'h088, 10'h075, 0);
    run_op(9'h180, 9'h080, 10'h180, 0);
    run_op(9'h088, 9'h000, 10'h2FF, 0);
    run_op(9'h188, 9'h000, 10'h3FF, 0);
    run_op(9'h000, 9'h088, 10'h000, 0);
    run_op(9'h010, 9'h0F0, 10'h000, 0);
    run_op(9'h0F0, 9'h010, 10'h0FF, 0);
    run_op(9'h080, 9'h088, 10'h075, 5);

    // Reset sampled on the third CALC cycle
    @(negedge clk);
    a = 9'h088;
    b = 9'h080;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_ready", in_ready, 1);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_c", c, 0);
    check_eq("midrst_dbz", div_by_zero, 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check_eq("midrst_no_pulse", pulses, 0);
    run_op(9'h088, 9'h080, 10'h088, 0);

    for (int k = 0; k < 40; k++) begin
      ra = 9'($urandom);
      rb = 9'($urandom);
      if ($urandom_range(0, 7) == 0) ra[7:4] = 4'h0;
      if ($urandom_range(0, 7) == 0) rb[7:4] = 4'h0;
      run_op(ra, rb, ref_div(ra, rb), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
